// File: rtl/wash_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : wash_phase_timer
// Description : Times each washing-machine phase (fill, wash, rinse, spin,
//               drain, dry) from a duration table selected by the cycle
//               configuration latched at start. Emits a single-cycle done
//               pulse per phase, supports pause/resume freezing, and flags
//               illegal multi-phase enables.
// Revision    : 1.0 - initial release
// ============================================================================
module wash_phase_timer #(
  parameter int TICK_DIV = 60,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             fill_active,
  input  logic             wash_active,
  input  logic             rinse_active,
  input  logic             spin_active,
  input  logic             drain_active,
  input  logic             dry_active,
  input  logic             pause,
  input  logic             resume,
  input  logic [1:0]       temp_select,
  input  logic [1:0]       cloth_type,
  input  logic [1:0]       cycle_duration,
  output logic             fill_done,
  output logic             wash_done,
  output logic             rinse_done,
  output logic             spin_done,
  output logic             drain_done,
  output logic             dry_done,
  output logic             paused,
  output logic [CNT_W-1:0] remaining,
  output logic             phase_err
);

  localparam int                PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_PAUSED = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t           state;
  logic [PRE_W-1:0] prescale;
  logic [2:0]       phase;
  logic [5:0]       done_q;
  logic [1:0]       cfg_temp;
  logic [1:0]       cfg_cloth;
  logic [1:0]       cfg_cycle;

  logic [5:0]       enables;
  logic             any_en;
  logic             multi_en;
  logic             single_en;
  logic [2:0]       new_code;
  logic [CNT_W-1:0] new_dur;
  logic             load_req;
  logic             advance;
  logic             tick_wrap;

  // Bit position of each enable doubles as its 3-bit phase code.
  assign enables   = {dry_active, drain_active, spin_active,
                      rinse_active, wash_active, fill_active};
  assign any_en    = |enables;
  assign multi_en  = |(enables & (enables - 6'd1));
  assign single_en = any_en & ~multi_en;
  assign tick_wrap = (prescale == PRE_LAST);

  // Encode the single active enable into a phase code.
  always_comb begin
    new_code = 3'd0;
    case (enables)
      6'b000001: new_code = 3'd0;
      6'b000010: new_code = 3'd1;
      6'b000100: new_code = 3'd2;
      6'b001000: new_code = 3'd3;
      6'b010000: new_code = 3'd4;
      6'b100000: new_code = 3'd5;
      default:   new_code = 3'd0;
    endcase
  end

  // Look up the tick count of the requested phase from the latched config.
  always_comb begin
    new_dur = CNT_W'(2);
    case (new_code)
      3'd1: begin
        case (cfg_cycle)
          2'b01:   new_dur = CNT_W'(18);
          2'b10:   new_dur = CNT_W'(26);
          default: new_dur = CNT_W'(10);
        endcase
      end
      3'd2:    new_dur = (cfg_cloth == 2'b00) ? CNT_W'(6) : CNT_W'(4);
      3'd3:    new_dur = (cfg_cloth == 2'b00) ? CNT_W'(5) : CNT_W'(3);
      3'd5: begin
        case (cfg_temp)
          2'b01:   new_dur = CNT_W'(6);
          2'b10:   new_dur = CNT_W'(8);
          default: new_dur = CNT_W'(4);
        endcase
      end
      default: new_dur = CNT_W'(2);
    endcase
  end

  // A fresh single enable (from idle/error, or a different phase) reloads.
  always_comb begin
    load_req = 1'b0;
    if (single_en) begin
      case (state)
        S_IDLE, S_ERR:           load_req = 1'b1;
        S_RUN, S_PAUSED, S_DONE: load_req = (new_code != phase);
        default:                 load_req = 1'b0;
      endcase
    end
  end

  // Timer moves on in RUN unless this edge pauses it, and on the resuming edge.
  always_comb begin
    advance = 1'b0;
    if (single_en && !load_req) begin
      case (state)
        S_RUN:    advance = !(pause && !resume);
        S_PAUSED: advance = resume && !pause;
        default:  advance = 1'b0;
      endcase
    end
  end

  // Phase state machine, prescaler, countdown, config latch and pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      prescale  <= '0;
      remaining <= '0;
      phase     <= 3'd0;
      done_q    <= '0;
      paused    <= 1'b0;
      phase_err <= 1'b0;
      cfg_temp  <= 2'b00;
      cfg_cloth <= 2'b00;
      cfg_cycle <= 2'b00;
    end else begin
      done_q <= '0;

      if (start && !any_en) begin
        cfg_temp  <= temp_select;
        cfg_cloth <= cloth_type;
        cfg_cycle <= cycle_duration;
      end

      if (multi_en) begin
        state     <= S_ERR;
        phase_err <= 1'b1;
        paused    <= 1'b0;
      end else if (load_req) begin
        state     <= S_RUN;
        phase     <= new_code;
        remaining <= new_dur;
        prescale  <= '0;
        paused    <= 1'b0;
        phase_err <= 1'b0;
      end else if (!any_en) begin
        // Dropping the enable mid-phase is an abort: clear without a pulse.
        if (state == S_RUN || state == S_PAUSED) begin
          remaining <= '0;
          prescale  <= '0;
        end
        state     <= S_IDLE;
        paused    <= 1'b0;
        phase_err <= 1'b0;
      end else begin
        if (state == S_RUN && pause && !resume) begin
          state  <= S_PAUSED;
          paused <= 1'b1;
        end
        if (state == S_PAUSED && resume && !pause) begin
          state  <= S_RUN;
          paused <= 1'b0;
        end
        if (advance) begin
          if (tick_wrap) begin
            prescale  <= '0;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              done_q <= 6'(1) << phase;
              state  <= S_DONE;
            end
          end else begin
            prescale <= prescale + PRE_W'(1);
          end
        end
      end
    end
  end

  assign fill_done  = done_q[0];
  assign wash_done  = done_q[1];
  assign rinse_done = done_q[2];
  assign spin_done  = done_q[3];
  assign drain_done = done_q[4];
  assign dry_done   = done_q[5];

endmodule
`default_nettype wire

// File: tb/tb_wash_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wash_phase_timer
// Description : Self-checking bench for wash_phase_timer: directed scenarios
//               plus randomized controller traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wash_phase_timer;

  localparam int TD = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic [5:0] en;
  logic       pause;
  logic       resume;
  logic [1:0] temp;
  logic [1:0] cloth;
  logic [1:0] cyc;
  logic       fill_done, wash_done, rinse_done, spin_done, drain_done, dry_done;
  logic       paused;
  logic [7:0] remaining;
  logic       phase_err;
  logic [5:0] done_vec;

  int total = 0;
  int bad   = 0;

  assign done_vec = {dry_done, drain_done, spin_done, rinse_done, wash_done, fill_done};

  wash_phase_timer #(.TICK_DIV(TD), .CNT_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .fill_active    (en[0]),
    .wash_active    (en[1]),
    .rinse_active   (en[2]),
    .spin_active    (en[3]),
    .drain_active   (en[4]),
    .dry_active     (en[5]),
    .pause          (pause),
    .resume         (resume),
    .temp_select    (temp),
    .cloth_type     (cloth),
    .cycle_duration (cyc),
    .fill_done      (fill_done),
    .wash_done      (wash_done),
    .rinse_done     (rinse_done),
    .spin_done      (spin_done),
    .drain_done     (drain_done),
    .dry_done       (dry_done),
    .paused         (paused),
    .remaining      (remaining),
    .phase_err      (phase_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (phase-level, tick arithmetic) ---------
  // mode: 0 idle, 1 timing (running or paused), 2 finished, 3 error
  int         m_mode, m_ph, m_dur, m_act, m_rem;
  bit         m_pz;
  logic [5:0] m_done;
  logic [1:0] m_temp, m_cloth, m_cyc;

  function automatic int dur_of(input int code);
    int c, t;
    c = (m_cyc == 2'd3) ? 0 : int'(m_cyc);
    t = (m_temp == 2'd3) ? 0 : int'(m_temp);
    case (code)
      1:       return 10 + 8 * c;
      2:       return (m_cloth == 2'd0) ? 6 : 4;
      3:       return (m_cloth == 2'd0) ? 5 : 3;
      5:       return 4 + 2 * t;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ph = -1; m_dur = 0; m_act = 0; m_rem = 0; m_pz = 0;
    m_done = '0; m_temp = '0; m_cloth = '0; m_cyc = '0;
  endtask

  task automatic model_step();
    int n, code;
    bit adv;
    n = $countones(en);
    code = -1;
    for (int i = 0; i < 6; i++) if (en[i]) code = i;
    m_done = '0;
    adv = 0;
    if (start && en == 6'd0) begin
      m_temp = temp; m_cloth = cloth; m_cyc = cyc;
    end
    if (n >= 2) begin
      if (m_mode != 3) begin m_mode = 3; m_pz = 0; m_ph = -1; end
    end else if (n == 1 && (m_mode == 0 || m_mode == 3 || code != m_ph)) begin
      m_mode = 1; m_ph = code; m_dur = dur_of(code); m_act = 0; m_rem = m_dur; m_pz = 0;
    end else if (n == 0) begin
      if (m_mode == 1) m_rem = 0;
      m_mode = 0; m_pz = 0;
    end else if (m_mode == 1) begin
      if (!m_pz) begin
        if (pause && !resume) m_pz = 1; else adv = 1;
      end else if (resume && !pause) begin
        m_pz = 0; adv = 1;
      end
      if (adv) begin
        m_act++;
        m_rem = m_dur - m_act / TD;
        if (m_act == m_dur * TD) begin
          m_done[m_ph] = 1'b1;
          m_mode = 2;
        end
      end
    end
  endtask

  // Every cycle: step the model, then compare all outputs after the edge.
  always @(posedge clk) begin
    if (reset) model_reset(); else model_step();
    #1;
    check_eq("m_rem",    32'(remaining), 32'(m_rem));
    check_eq("m_paused", 32'(paused),    32'(m_pz));
    check_eq("m_err",    32'(phase_err), 32'(m_mode == 3));
    check_eq("m_done",   32'(done_vec),  32'(m_done));
  end

  // ---------------- directed helpers ----------------
  task automatic set_cfg(input logic [1:0] t, input logic [1:0] c, input logic [1:0] d);
    @(negedge clk);
    en = '0; start = 1'b1; temp = t; cloth = c; cyc = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_phase(input int idx, input int dur, input string tag);
    int  k;
    bit  seen;
    @(negedge clk);
    en = 6'(1) << idx;
    @(posedge clk); #1;
    check_eq({tag, "_rem_e0"}, 32'(remaining), 32'(dur));
    check_eq({tag, "_err_e0"}, 32'(phase_err), 32'd0);
    seen = 0; k = 0;
    while (!seen && k < dur * TD + 20) begin
      @(posedge clk); #1;
      k++;
      if (done_vec != 6'd0) begin
        seen = 1;
        check_eq({tag, "_which"}, 32'(done_vec), 32'(1) << idx);
      end
    end
    check_eq({tag, "_time"}, 32'(k), 32'(dur * TD));
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done_vec != 6'd0) pulses++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses, donek, r;
    int seq_d[6];
    reset = 1'b1; start = 0; en = '0; pause = 0; resume = 0;
    temp = '0; cloth = '0; cyc = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_rem",    32'(remaining), 32'd0);
    check_eq("rst_paused", 32'(paused),    32'd0);
    check_eq("rst_err",    32'(phase_err), 32'd0);
    check_eq("rst_done",   32'(done_vec),  32'd0);

    // Medium wash: 18 ticks, single pulse only.
    set_cfg(2'd0, 2'd0, 2'd1);
    run_phase(1, 18, "wash_med");
    count_pulses(12, pulses);
    check_eq("wash_nodup", 32'(pulses), 32'd0);

    // Dry with hot, then temp 11 (treated as cold).
    set_cfg(2'd2, 2'd0, 2'd0);
    run_phase(5, 8, "dry_hot");
    set_cfg(2'd3, 2'd0, 2'd0);
    run_phase(5, 4, "dry_t3");
    // Start during fill must not change the latched config.
    start = 1'b1; temp = 2'd2;
    run_phase(0, 2, "fill_start");
    start = 1'b0;
    run_phase(5, 4, "dry_keep");

    // Cotton rinse with a 10-cycle pause beginning at E0+5.
    @(negedge clk);
    en = 6'b000100;
    @(posedge clk); #1;
    check_eq("rinse_rem_e0", 32'(remaining), 32'd6);
    donek = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      pause  = (k >= 5 && k <= 14);
      resume = (k == 8 || k == 9 || k == 15);
      @(posedge clk); #1;
      if (k >= 5 && k <= 14) begin
        check_eq("rinse_paused", 32'(paused),    32'd1);
        check_eq("rinse_frozen", 32'(remaining), 32'd5);
      end
      if (done_vec[2] && donek == 0) donek = k;
    end
    check_eq("rinse_time", 32'(donek), 32'd34);
    @(negedge clk);
    pause = 0; resume = 0; en = '0;

    // Spin aborted at E0+7.
    @(negedge clk);
    en = 6'b001000;
    @(posedge clk); #1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 7) en = '0;
      @(posedge clk); #1;
    end
    check_eq("spin_abort_rem",    32'(remaining), 32'd0);
    check_eq("spin_abort_paused", 32'(paused),    32'd0);
    count_pulses(30, pulses);
    check_eq("spin_nodone", 32'(pulses), 32'd0);

    // Reset in the middle of fill.
    @(negedge clk);
    en = 6'b000001;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("rstmid_rem",  32'(remaining), 32'd0);
    check_eq("rstmid_done", 32'(done_vec),  32'd0);
    check_eq("rstmid_err",  32'(phase_err), 32'd0);
    @(negedge clk);
    reset = 1'b0; en = '0;

    // Two enables at once, then recovery with fill alone.
    @(negedge clk);
    en = 6'b000011;
    @(posedge clk); #1;
    check_eq("err_rise", 32'(phase_err), 32'd1);
    count_pulses(4, pulses);
    check_eq("err_nopulse", 32'(pulses), 32'd0);
    run_phase(0, 2, "fill_after_err");

    // Back-to-back phases, controller advancing on each done.
    set_cfg(2'd1, 2'd1, 2'd2);
    seq_d = '{2, 26, 4, 3, 2, 6};
    for (int p = 0; p < 6; p++) run_phase(p, seq_d[p], $sformatf("seq%0d", p));
    @(negedge clk);
    en = '0;

    // Randomized controller traffic, checked every cycle by the model.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      start  = 1'b0;
      pause  = ($urandom_range(0, 14) == 0);
      resume = ($urandom_range(0, 7) == 0);
      if (en == 6'd0) begin
        r = $urandom_range(0, 9);
        if (r < 3) begin
          start = 1'b1; temp = 2'($urandom); cloth = 2'($urandom); cyc = 2'($urandom);
        end else if (r < 6) begin
          en = 6'(1) << $urandom_range(0, 5);
        end else if (r == 6) begin
          en = (6'(1) << $urandom_range(0, 5)) | (6'(1) << $urandom_range(0, 5));
        end
      end else if ($countones(en) > 1) begin
        if ($urandom_range(0, 2) == 0)
          en = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'(1) << $urandom_range(0, 5);
      end else if (done_vec != 6'd0) begin
        en = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'(1) << $urandom_range(0, 5);
      end else begin
        r = $urandom_range(0, 199);
        if (r == 0)      en = '0;
        else if (r == 1) en = 6'(1) << $urandom_range(0, 5);
        else if (r == 2) en = en | (6'(1) << $urandom_range(0, 5));
        else if (r < 8) begin
          start = 1'b1; temp = 2'($urandom); cloth = 2'($urandom); cyc = 2'($urandom);
        end
      end
    end
    @(negedge clk);
    en = '0; pause = 0; resume = 0; start = 0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
